// File: rtl/imem_load_ctrl.sv
// Boot loader: assembles UART bytes into 32-bit words, fills instruction memory, then releases the CPU.
// Optional trailing checksum byte enabled by IMEM_LOAD_CKSUM_EN.
module imem_load_ctrl #(
  parameter int unsigned NUM_WORDS  = 64,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned GAP_CYCLES = 1_000_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  input  logic              reload_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_rst_o,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic [ADDR_W:0]   words_loaded_o
);

  localparam int unsigned WL_W  = ADDR_W + 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

`ifdef IMEM_LOAD_CKSUM_EN
  typedef enum logic [1:0] {LOAD, WRITE, CHECK, RUN} state_e;
`else
  typedef enum logic [1:0] {LOAD, WRITE, RUN} state_e;
`endif

  state_e            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       asm_q, asm_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [WL_W-1:0]   words_q, words_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              we_q, we_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              byte_ok;
  logic              last_word;
`ifdef IMEM_LOAD_CKSUM_EN
  logic              err_q, err_d;
  logic [7:0]        csum_q, csum_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= LOAD;
      lane_q    <= 2'd0;
      asm_q     <= 24'd0;
      wdata_q   <= 32'd0;
      wr_ptr_q  <= '0;
      words_q   <= '0;
      gap_q     <= '0;
      we_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
`ifdef IMEM_LOAD_CKSUM_EN
      err_q     <= 1'b0;
      csum_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      asm_q     <= asm_d;
      wdata_q   <= wdata_d;
      wr_ptr_q  <= wr_ptr_d;
      words_q   <= words_d;
      gap_q     <= gap_d;
      we_q      <= we_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
`ifdef IMEM_LOAD_CKSUM_EN
      err_q     <= err_d;
      csum_q    <= csum_d;
`endif
    end
  end

  // Next-state logic: byte assembly, write sequencing, gap timeout, reload override
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    asm_d     = asm_q;
    wdata_d   = wdata_q;
    wr_ptr_d  = wr_ptr_q;
    words_d   = words_q;
    gap_d     = gap_q;
    we_d      = 1'b0;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
`ifdef IMEM_LOAD_CKSUM_EN
    err_d     = err_q;
    csum_d    = csum_q;
`endif
    byte_ok   = rx_valid_i && ((state_q == LOAD) || (state_q == WRITE));
    last_word = (wr_ptr_q == ADDR_W'(NUM_WORDS - 1));

    if (byte_ok) begin
      gap_d  = '0;
      lane_d = lane_q + 2'd1;
`ifdef IMEM_LOAD_CKSUM_EN
      csum_d = csum_q + rx_data_i;
`endif
      case (lane_q)
        2'd0: asm_d[7:0]   = rx_data_i;
        2'd1: asm_d[15:8]  = rx_data_i;
        2'd2: asm_d[23:16] = rx_data_i;
        2'd3: begin
          wdata_d = {rx_data_i, asm_q};
          we_d    = 1'b1;
          state_d = WRITE;
        end
        default: ;
      endcase
    end else if ((state_q == LOAD) && (lane_q != 2'd0)) begin
      // A stalled partial word is dropped so the host can resynchronise
      if (gap_q == GAP_W'(GAP_CYCLES)) begin
        lane_d = 2'd0;
        gap_d  = '0;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end

    case (state_q)
      WRITE: begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        words_d  = words_q + WL_W'(1);
        if (last_word) begin
`ifdef IMEM_LOAD_CKSUM_EN
          state_d   = CHECK;
`else
          state_d   = RUN;
          cpu_rst_d = 1'b0;
          done_d    = 1'b1;
`endif
        end else begin
          state_d = LOAD;
        end
      end
`ifdef IMEM_LOAD_CKSUM_EN
      CHECK: begin
        if (rx_valid_i) begin
          if (rx_data_i == csum_q) begin
            err_d     = 1'b0;
            state_d   = RUN;
            cpu_rst_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            err_d    = 1'b1;
            state_d  = LOAD;
            lane_d   = 2'd0;
            wr_ptr_d = '0;
            words_d  = '0;
            gap_d    = '0;
            csum_d   = 8'd0;
          end
        end
      end
`endif
      default: ;
    endcase

    // Reload wins over everything; a write already on the bus still completes
    if (reload_i) begin
      state_d   = LOAD;
      lane_d    = 2'd0;
      wr_ptr_d  = '0;
      words_d   = '0;
      gap_d     = '0;
      we_d      = 1'b0;
      cpu_rst_d = 1'b1;
      done_d    = 1'b0;
`ifdef IMEM_LOAD_CKSUM_EN
      csum_d    = 8'd0;
`endif
    end
  end

  assign imem_we_o      = we_q;
  assign imem_addr_o    = (state_q == RUN) ? fetch_addr_i : wr_ptr_q;
  assign imem_wdata_o   = wdata_q;
  assign cpu_rst_o      = cpu_rst_q;
  assign load_done_o    = done_q;
  assign words_loaded_o = words_q;
`ifdef IMEM_LOAD_CKSUM_EN
  assign load_err_o     = err_q;
`else
  assign load_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Scoreboard bench for imem_load_ctrl: a byte-level image model predicts writes and status.
// Checksum scenarios run only when IMEM_LOAD_CKSUM_EN is defined.
module tb_imem_load_ctrl;
  localparam int unsigned NW  = 4;
  localparam int unsigned AW  = 3;
  localparam int unsigned GAP = 20;

  logic          clk = 1'b0;
  logic          rst, rx_valid, reload;
  logic [7:0]    rx_data;
  logic [AW-1:0] fetch_addr;
  logic          imem_we, cpu_rst, load_done, load_err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   words_loaded;

  imem_load_ctrl #(.NUM_WORDS(NW), .ADDR_W(AW), .GAP_CYCLES(GAP)) dut (
    .clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .reload_i(reload), .fetch_addr_i(fetch_addr), .imem_we_o(imem_we),
    .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata), .cpu_rst_o(cpu_rst),
    .load_done_o(load_done), .load_err_o(load_err), .words_loaded_o(words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: the image as a byte stream
  logic [7:0]  m_bytes[$];
  int          m_ptr, m_words;
  bit          m_done, m_chk, m_err;
  logic [7:0]  m_sum;
  logic [31:0] m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reload();
    m_bytes.delete();
    m_ptr = 0; m_words = 0; m_done = 0; m_chk = 0; m_sum = 8'd0;
  endtask

  task automatic model_reset();
    model_reload();
    m_err = 0; m_last = 32'd0;
  endtask

  task automatic model_accept(input logic [7:0] b, input int c);
    logic [31:0] w;
    if (m_done) return;
    if (m_chk) begin
      m_chk = 0;
      if (b == m_sum) begin m_err = 0; m_done = 1; end
      else begin m_err = 1; model_reload(); end
      return;
    end
    m_sum = m_sum + b;
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      exp_q.push_back('{addr: AW'(m_ptr), data: w, cyc: c + 1});
      m_last = w;
      m_ptr++; m_words++;
      m_bytes.delete();
      if (m_words == NW) begin
`ifdef IMEM_LOAD_CKSUM_EN
        m_chk = 1;
`else
        m_done = 1;
`endif
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rl = 1'b0);
    rx_valid = 1'b1; rx_data = b; reload = rl;
    if (rl) model_reload(); else model_accept(b, cyc);
    @(posedge clk); #1;
    rx_valid = 1'b0; reload = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
    if (n > int'(GAP) + 2) m_bytes.delete();
  endtask

  task automatic check_status(input string tag);
    check({tag, "_words"}, 32'(words_loaded), 32'(m_words));
    check({tag, "_done"}, 32'(load_done), 32'(m_done));
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!m_done));
    check({tag, "_err"}, 32'(load_err), 32'(m_err));
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_image(input logic [7:0] img[16]);
    for (int i = 0; i < 16; i++) send_byte(img[i]);
  endtask

  // Monitor: every write must match the oldest predicted write, in the predicted cycle
  bit prev_we = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_we) begin
        checks++;
        if (prev_we) begin
          errors++;
          $display("FAIL we_back_to_back at cycle %0d", cyc);
        end
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0d data=%h cycle=%0d", imem_addr, imem_wdata, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("write_addr", 32'(imem_addr), 32'(e.addr));
          check("write_data", imem_wdata, e.data);
          check("write_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      prev_we = imem_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  logic [7:0] img[16];
  logic [7:0] rimg[16];

  initial begin
    img = '{8'h93, 8'h02, 8'hA0, 8'h00, 8'hB3, 8'h80, 8'h50, 8'h00,
            8'h83, 8'h32, 8'h20, 8'h00, 8'hE3, 8'h0E, 8'h00, 8'hFE};
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; reload = 1'b0; fetch_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check_status("rst");
    rst = 1'b0;
    idle(1);

    // Known image, back-to-back bytes
    send_image(img);
    check("we_after_last", 32'(imem_we), 32'd1);
    check("done_not_early", 32'(load_done), 32'd0);
    idle(1);
    check_status("img");
`ifdef IMEM_LOAD_CKSUM_EN
    check("model_sum", 32'(m_sum), 32'h7C);
    send_byte(8'h7C);
    idle(1);
    check_status("cksum_ok");
`endif

    // RUN: combinational address mux, bytes ignored
    fetch_addr = 3'd2; #1;
    check("fetch_mux", 32'(imem_addr), 32'd2);
    for (int i = 0; i < 3; i++) begin
      fetch_addr = AW'($urandom_range(0, 7)); #1;
      check("fetch_mux_rnd", 32'(imem_addr), 32'(fetch_addr));
    end
    idle(1);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    idle(2);
    check_status("run_ignore");

    // Reload holds write data; gap discards a partial word
    send_byte(8'h55, 1'b1);
    check_status("reload1");
    check("reload_wdata_hold", imem_wdata, m_last);
    check("reload_addr", 32'(imem_addr), 32'd0);
    send_byte(8'h93); send_byte(8'h02);
    idle(25);
    send_word(32'h0000_0013);
    idle(1);
    check_status("gap");
    send_word($urandom);
    idle(1);
    check_status("two_words");
    // Reload together with a byte: the byte must be dropped
    send_byte(8'hAA, 1'b1);
    check_status("reload2");
    send_word(32'h4433_2211);
    idle(1);
    check_status("after_reload2");

    // Reset during a partial word
    send_byte(8'h77); send_byte(8'h66);
    fetch_addr = 3'd5;
    rst = 1'b1; model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_we", 32'(imem_we), 32'd0);
    check("mid_rst_wdata", imem_wdata, 32'd0);
    check("mid_rst_addr", 32'(imem_addr), 32'd0);
    check_status("mid_rst");
    send_word(32'hDEAD_BEEF);
    idle(1);
    check_status("post_rst");

    // Random images with random inter-byte spacing
    for (int it = 0; it < 3; it++) begin
      send_byte(8'h00, 1'b1);
      for (int i = 0; i < 16; i++) begin
        send_byte(8'($urandom));
        idle($urandom_range(0, 3));
      end
      idle(1);
`ifdef IMEM_LOAD_CKSUM_EN
      send_byte(m_sum);
      idle(1);
`endif
      check_status("rand_img");
    end

`ifdef IMEM_LOAD_CKSUM_EN
    // Bad checksum then a clean reload
    send_byte(8'h00, 1'b1);
    send_image(img);
    idle(1);
    send_byte(8'h7D);
    idle(1);
    check_status("cksum_bad");
    check("cksum_bad_err", 32'(load_err), 32'd1);
    send_byte(8'h00, 1'b1);
    send_image(img);
    idle(1);
    send_byte(8'h7C);
    idle(1);
    check_status("cksum_recover");
    check("cksum_recover_done", 32'(load_done), 32'd1);
`endif

    idle(3);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
